// File: rtl/rptr_ctrl.sv
// Read-side pointer and flag controller for an asynchronous FIFO (single clock, rclk).
// Define RPTR_CTRL_UNDERFLOW_EN to build the sticky read-while-empty detector.
module rptr_ctrl #(
    parameter int PTR_WIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 r_en,
    input  logic [PTR_WIDTH:0]   g_wptr_sync,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 rd_valid,
    output logic                 underflow
);

    localparam logic [PTR_WIDTH:0] AE_T = AE_THRESH[PTR_WIDTH:0];

    logic [PTR_WIDTH:0] b_rptr_q, b_rptr_d;
    logic [PTR_WIDTH:0] g_rptr_q, g_rptr_d;
    logic [PTR_WIDTH:0] rd_count_q, rd_count_d;
    logic [PTR_WIDTH:0] b_wptr_sync;
    logic               empty_q, empty_d;
    logic               almost_empty_q, almost_empty_d;
    logic               rd_valid_q;
    logic               acc;

    assign acc = r_en & ~empty_q;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        b_wptr_sync = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            b_wptr_sync[i] = ^(g_wptr_sync >> i);
        end
    end

    always_comb begin
        b_rptr_d       = b_rptr_q + {{PTR_WIDTH{1'b0}}, acc};
        g_rptr_d       = (b_rptr_d >> 1) ^ b_rptr_d;
        empty_d        = (g_rptr_d == g_wptr_sync);
        rd_count_d     = b_wptr_sync - b_rptr_d;
        almost_empty_d = (rd_count_d <= AE_T);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            b_rptr_q       <= '0;
            g_rptr_q       <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_count_q     <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            b_rptr_q       <= b_rptr_d;
            g_rptr_q       <= g_rptr_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            rd_count_q     <= rd_count_d;
            rd_valid_q     <= acc;
        end
    end

`ifdef RPTR_CTRL_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            underflow_q <= 1'b0;
        end else if (r_en && empty_q) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

    assign b_rptr       = b_rptr_q;
    assign g_rptr       = g_rptr_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign rd_count     = rd_count_q;
    assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_rptr_ctrl.sv
// Bench for rptr_ctrl (PTR_WIDTH=3, AE_THRESH=1): driver pushes expected post-edge state,
// monitor pops one entry per clock and compares every output.
module tb_rptr_ctrl;

  localparam int W = 16;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       r_en;
  logic [3:0] g_wptr_sync;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_count;
  logic       rd_valid;
  logic       underflow;

  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] prev_g = 4'b0000;

  rptr_ctrl #(.PTR_WIDTH(3), .AE_THRESH(1)) dut (
    .rclk(rclk),
    .rrst(rrst),
    .r_en(r_en),
    .g_wptr_sync(g_wptr_sync),
    .b_rptr(b_rptr),
    .g_rptr(g_rptr),
    .empty(empty),
    .almost_empty(almost_empty),
    .rd_count(rd_count),
    .rd_valid(rd_valid),
    .underflow(underflow)
  );

  // clock
  always #5 rclk = ~rclk;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_reset_state();
    chk("rst_b_rptr", {28'd0, b_rptr}, 32'd0);
    chk("rst_g_rptr", {28'd0, g_rptr}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_almost_empty", {31'd0, almost_empty}, 32'd1);
    chk("rst_rd_count", {28'd0, rd_count}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
  endtask

  // driver: apply inputs for the next edge and queue the state expected after it
  task automatic step(input logic ren, input logic [3:0] gw,
                      input logic [3:0] eb, input logic [3:0] eg,
                      input logic ee, input logic eae, input logic [3:0] ecnt,
                      input logic ev, input logic euf);
    logic euf_m;
`ifdef RPTR_CTRL_UNDERFLOW_EN
    euf_m = euf;
`else
    euf_m = 1'b0;
`endif
    @(negedge rclk);
    r_en        = ren;
    g_wptr_sync = gw;
    exp_q.push_back({eb, eg, ee, eae, ecnt, ev, euf_m});
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge rclk);
      #2;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: got %0d entries expected 0", exp_q.size());
      n_total++;
      exp_q.delete();
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge rclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("b_rptr", {28'd0, b_rptr}, {28'd0, e[15:12]});
        chk("g_rptr", {28'd0, g_rptr}, {28'd0, e[11:8]});
        chk("empty", {31'd0, empty}, {31'd0, e[7]});
        chk("almost_empty", {31'd0, almost_empty}, {31'd0, e[6]});
        chk("rd_count", {28'd0, rd_count}, {28'd0, e[5:2]});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e[1]});
        chk("underflow", {31'd0, underflow}, {31'd0, e[0]});
        chk("g_rptr_one_bit", {31'd0, ($countones(g_rptr ^ prev_g) <= 1)}, 32'd1);
        prev_g = g_rptr;
      end
    end
  end

  initial begin
    rrst        = 1'b1;
    r_en        = 1'b0;
    g_wptr_sync = 4'b0000;
    repeat (3) @(posedge rclk);
    #2;
    chk_reset_state();

    @(negedge rclk);
    rrst = 1'b0;

    // fill: write pointer at binary 3
    step(1'b0, 4'b0010, 4'd0, 4'b0000, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    // drain 3 words, then one read while empty
    step(1'b1, 4'b0010, 4'd1, 4'b0001, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 4'd2, 4'b0011, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    // underflow persists; pointers frozen
    step(1'b1, 4'b0010, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'b0010, 4'd3, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);

    // write pointer jumps to 15 while still empty: no read accepted this edge
    step(1'b1, 4'b1000, 4'd3, 4'b0010, 1'b0, 1'b0, 4'd12, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 4'b1000, 4'(3 + k), gray(4'(3 + k)), (k == 12),
           ((12 - k) <= 1), 4'(12 - k), 1'b1, 1'b1);
    end

    // wrap: b_rptr 15 -> 0 with write pointer at 1 (wrapped)
    step(1'b0, 4'b0001, 4'd15, 4'b1000, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1);
    step(1'b1, 4'b0001, 4'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);

    // full occupancy: write pointer at binary 8
    step(1'b0, 4'b1100, 4'd0, 4'b0000, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1);
    drain();

    // asynchronous reset between clock edges
    rrst = 1'b1;
    #1;
    chk_reset_state();
    @(negedge rclk);
    rrst = 1'b0;
    step(1'b0, 4'b1100, 4'd0, 4'b0000, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rptr_ctrl.md
RPTR_CTRL -- requirements
Module: rptr_ctrl

Interface
REQ-001 Parameter PTR_WIDTH, default 3, SHALL set pointer width; FIFO depth is 2^PTR_WIDTH and pointers are PTR_WIDTH+1 bits.
REQ-002 Parameter AE_THRESH, default 1, SHALL set the almost-empty occupancy threshold, valid range 0..2^PTR_WIDTH.
REQ-003 rclk  input  1  read-domain clock; the block has one clock and SHALL sample all state on its rising edge.
REQ-004 rrst  input  1  reset; asynchronous, active-high.
REQ-005 r_en  input  1  read request from the consumer.
REQ-006 g_wptr_sync  input  PTR_WIDTH+1  Gray write pointer, already synchronised into rclk.
REQ-007 b_rptr  output  PTR_WIDTH+1  binary read pointer; bits [PTR_WIDTH-1:0] address the FIFO memory.
REQ-008 g_rptr  output  PTR_WIDTH+1  Gray read pointer, sent to the write domain.
REQ-009 empty  output  1  FIFO empty flag, registered.
REQ-010 almost_empty  output  1  occupancy <= AE_THRESH, registered.
REQ-011 rd_count  output  PTR_WIDTH+1  read-side occupancy, 0..2^PTR_WIDTH, registered.
REQ-012 rd_valid  output  1  one-cycle pulse one clock after an accepted read; memory data valid.
REQ-013 underflow  output  1  sticky read-while-empty indicator.

Function
REQ-014 A read SHALL be accepted when r_en=1 and empty=0; acc = r_en & ~empty.
REQ-015 b_rptr_next SHALL be b_rptr + acc, modulo 2^(PTR_WIDTH+1); the pointer wraps from all-ones to 0.
REQ-016 g_rptr_next SHALL be (b_rptr_next >> 1) ^ b_rptr_next; b_rptr and g_rptr SHALL both register their next values every clock.
REQ-017 empty SHALL register (g_rptr_next == g_wptr_sync); a read that drains the last word SHALL set empty on the same edge that commits it.
REQ-018 b_wptr_sync SHALL be the combinational Gray-to-binary conversion of g_wptr_sync: MSB copied, each lower bit the XOR of the higher binary bit and its Gray bit.
REQ-019 rd_count SHALL register (b_wptr_sync - b_rptr_next) modulo 2^(PTR_WIDTH+1); the value 2^PTR_WIDTH (full) SHALL be representable.
REQ-020 almost_empty SHALL register (count_next <= AE_THRESH), where count_next is the rd_count next value; empty=1 implies almost_empty=1.
REQ-021 rd_valid SHALL register acc, giving a 1-cycle read latency aligned to the synchronous memory output.
REQ-022 r_en=1 while empty=1 SHALL leave b_rptr and g_rptr unchanged and SHALL NOT pulse rd_valid.
REQ-023 A write pointer change and an accepted read in the same cycle SHALL both be reflected in the same registered update of empty and rd_count.
REQ-024 g_rptr SHALL change by at most one bit per clock.

Reset
REQ-025 While rrst=1: b_rptr=0, g_rptr=0, empty=1, almost_empty=1, rd_count=0, rd_valid=0, underflow=0.
REQ-026 Assertion of rrst mid-operation SHALL clear state immediately, without waiting for rclk.
REQ-027 On the first rclk edge after rrst deasserts, the block SHALL evaluate normally from the reset values.

Configuration
REQ-028 Macro RPTR_CTRL_UNDERFLOW_EN defined: underflow SHALL set on the clock edge where r_en=1 and empty=1, and SHALL stay set until rrst.
REQ-029 Macro undefined: underflow SHALL be tied to 0 and the detection logic SHALL be absent; all other behaviour is unchanged.

Verification (PTR_WIDTH=3, AE_THRESH=1)
REQ-030 Reset test: rrst=1 with g_wptr_sync=4'b0000 -> empty=1, almost_empty=1, rd_count=0, b_rptr=0, g_rptr=0.
REQ-031 Fill test: g_wptr_sync=4'b0010 (binary 3), r_en=0, one clock -> empty=0, rd_count=3, almost_empty=0.
REQ-032 Drain test: continue from REQ-031 and hold r_en=1 for 4 clocks -> rd_count 2,1,0,0; almost_empty=1 from count 1; empty=1 after the third read; rd_valid pulses on exactly 3 cycles; b_rptr=3.
REQ-033 Underflow test: r_en=1 while empty -> b_rptr stays constant, rd_valid=0; underflow=1 and stays set with macro defined, and stays 0 without it.
REQ-034 Wrap test: preset b_rptr=15 with g_wptr_sync=gray(1)=4'b0001, then read -> b_rptr=0, g_rptr goes 4'b1000 to 4'b0000, empty=0, rd_count=1.
REQ-035 Full-occupancy test: b_rptr=0 and g_wptr_sync=4'b1100 (binary 8) -> rd_count=8, empty=0, almost_empty=0.
